dmi_req_sequencer: RTL

// - Core-clock-side DMI controller: shares one Debug Module (DM) register port between two requesters,

---
 rtl/dmi_pkg.sv | 28 ++
 rtl/dmi_rr_arb2.sv | 39 +++
 rtl/dmi_req_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared types for the DMI request sequencer.
// States, requester ids and DMI op-status codes.
package dmi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP
  } dmi_state_e;

  typedef enum logic {
    REQ_JTAG,
    REQ_SEC
  } dmi_req_id_e;

  localparam logic [1:0] DMI_OK   = 2'b00;
  localparam logic [1:0] DMI_FAIL = 2'b10;
  localparam logic [1:0] DMI_BUSY = 2'b11;

  function automatic logic [1:0] jtag_status(
    input logic [1:0] stk,
    input logic [1:0] op
  );
    return (stk != DMI_OK) ? stk : op;
  endfunction

endpackage

// File: rtl/dmi_rr_arb2.sv
// Two-way round-robin arbiter between JTAG and secondary host.
// Pointer names the favoured side and moves only on a grant.
module dmi_rr_arb2
  import dmi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        en_i,
  input  logic        req_j_i,
  input  logic        req_s_i,
  output logic        gnt_o,
  output dmi_req_id_e id_o
);

  dmi_req_id_e ptr_q, ptr_d;

  always_comb begin
    gnt_o = en_i & (req_j_i | req_s_i);
    id_o  = REQ_JTAG;
    unique case (1'b1)
      (req_j_i & req_s_i):  id_o = ptr_q;
      (req_s_i & !req_j_i): id_o = REQ_SEC;
      default:              id_o = REQ_JTAG;
    endcase
    ptr_d = ptr_q;
    if (gnt_o) begin
      ptr_d = (id_o == REQ_JTAG) ? REQ_SEC : REQ_JTAG;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr_q <= REQ_JTAG;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmi_req_sequencer.sv
// Core-side DMI controller: arbitrates JTAG and a secondary host
// onto one DM port, with timeout and JTAG sticky op-status.
module dmi_req_sequencer
  import dmi_pkg::*;
#(
  parameter int AWIDTH    = 7,
  parameter int TIMEOUT   = 255,
  parameter int IDLE_HINT = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              j_wr_en,
  input  logic              j_rd_en,
  input  logic [AWIDTH-1:0] j_addr,
  input  logic [31:0]       j_wdata,
  input  logic              j_dmi_reset,
  input  logic              j_dmi_hard_rst,
  output logic              j_rsp_vld,
  output logic [31:0]       j_rdata,
  output logic [1:0]        j_status,
  output logic [1:0]        dmi_stat,
  output logic [2:0]        idle,
  input  logic              s_req_vld,
  output logic              s_req_rdy,
  input  logic              s_we,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic              s_rsp_vld,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_status,
  output logic              dm_req_vld,
  input  logic              dm_req_rdy,
  output logic              dm_we,
  output logic [AWIDTH-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_rsp_vld,
  input  logic [31:0]       dm_rsp_rdata,
  input  logic              dm_rsp_err,
  output logic              busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);

  dmi_state_e        state_q, state_d;
  dmi_req_id_e       own_q, own_d;
  logic              req_we_q, req_we_d;
  logic [AWIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic              jp_q, jp_d;
  logic              jp_we_q, jp_we_d;
  logic [AWIDTH-1:0] jp_addr_q, jp_addr_d;
  logic [31:0]       jp_wdata_q, jp_wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        opst_q, opst_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        stk_q, stk_d;
  logic [31:0]       jrd_q, jrd_d;
  logic [1:0]        jst_q, jst_d;

  logic        hard;
  logic        pulse;
  logic        j_busy;
  logic        drop;
  logic        in_fl;
  logic        arb_en;
  logic        gnt;
  dmi_req_id_e gnt_id;
  logic        to_hit;
  logic        j_rsp;
  logic        j_fail;
  logic        s_abort;
  logic [1:0]  j_st_now;

  assign hard   = j_dmi_hard_rst;
  assign pulse  = j_wr_en | j_rd_en;
  assign in_fl  = (state_q != IDLE);
  assign j_busy = jp_q | (in_fl & (own_q == REQ_JTAG));
  assign drop   = pulse & j_busy;
  assign arb_en = (state_q == IDLE) & !hard;
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_END);

  dmi_rr_arb2 u_arb (
    .clk     (clk),
    .rst_l   (rst_l),
    .en_i    (arb_en),
    .req_j_i (jp_q),
    .req_s_i (s_req_vld),
    .gnt_o   (gnt),
    .id_o    (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    jp_d        = jp_q;
    jp_we_d     = jp_we_q;
    jp_addr_d   = jp_addr_q;
    jp_wdata_d  = jp_wdata_q;
    cnt_d       = cnt_q;
    opst_d      = opst_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = ISSUE;
          own_d   = gnt_id;
          if (gnt_id == REQ_JTAG) begin
            req_we_d    = jp_we_q;
            req_addr_d  = jp_addr_q;
            req_wdata_d = jp_wdata_q;
            jp_d        = 1'b0;
          end else begin
            req_we_d    = s_we;
            req_addr_d  = s_addr;
            req_wdata_d = s_wdata;
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (dm_req_rdy) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dm_rsp_vld) begin
          state_d = RESP;
          opst_d  = dm_rsp_err ? DMI_FAIL : DMI_OK;
          rdata_d = req_we_q ? '0 : dm_rsp_rdata;
        end else if (to_hit) begin
          state_d = RESP;
          opst_d  = DMI_FAIL;
          rdata_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A pulse only lands when no JTAG op is pending or in flight
    if (pulse && !j_busy) begin
      jp_d       = 1'b1;
      jp_we_d    = j_wr_en;
      jp_addr_d  = j_addr;
      jp_wdata_d = j_wdata;
    end
    if (hard) begin
      state_d = IDLE;
      jp_d    = 1'b0;
    end
  end

  assign j_rsp  = (state_q == RESP) & (own_q == REQ_JTAG) & !hard;
  assign j_fail = j_rsp & (opst_q == DMI_FAIL);

  always_comb begin
    stk_d = stk_q;
    if (hard) begin
      stk_d = DMI_OK;
    end else if (j_fail) begin
      stk_d = (stk_q == DMI_OK || j_dmi_reset) ? DMI_FAIL : stk_q;
    end else if (j_dmi_reset) begin
      stk_d = DMI_OK;
    end else if (drop && stk_q == DMI_OK) begin
      stk_d = DMI_BUSY;
    end
    j_st_now = jtag_status(stk_d, opst_q);
    jrd_d    = j_rsp ? rdata_q : jrd_q;
    jst_d    = j_rsp ? j_st_now : jst_q;
  end

  assign s_abort = hard & in_fl & (own_q == REQ_SEC);

  always_comb begin
    j_rsp_vld = j_rsp;
    j_rdata   = j_rsp ? rdata_q : jrd_q;
    j_status  = j_rsp ? j_st_now : jst_q;
    s_req_rdy = gnt & (gnt_id == REQ_SEC);
    s_rsp_vld = ((state_q == RESP) & (own_q == REQ_SEC)) | s_abort;
    s_rdata   = '0;
    s_status  = DMI_OK;
    if (s_rsp_vld) begin
      s_rdata  = hard ? '0 : rdata_q;
      s_status = hard ? DMI_FAIL : opst_q;
    end
  end

  assign dm_req_vld = (state_q == ISSUE);
  assign dm_we      = req_we_q;
  assign dm_addr    = req_addr_q;
  assign dm_wdata   = req_wdata_q;
  assign busy       = in_fl | jp_q;
  assign dmi_stat   = stk_q;
  assign idle       = 3'(IDLE_HINT);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      own_q       <= REQ_JTAG;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      jp_q        <= 1'b0;
      jp_we_q     <= 1'b0;
      jp_addr_q   <= '0;
      jp_wdata_q  <= '0;
      cnt_q       <= '0;
      opst_q      <= DMI_OK;
      rdata_q     <= '0;
      stk_q       <= DMI_OK;
      jrd_q       <= '0;
      jst_q       <= DMI_OK;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      jp_q        <= jp_d;
      jp_we_q     <= jp_we_d;
      jp_addr_q   <= jp_addr_d;
      jp_wdata_q  <= jp_wdata_d;
      cnt_q       <= cnt_d;
      opst_q      <= opst_d;
      rdata_q     <= rdata_d;
      stk_q       <= stk_d;
      jrd_q       <= jrd_d;
      jst_q       <= jst_d;
    end
  end

endmodule
